// File: rtl/dm_arbiter_if.sv
// Data-memory port bundle: CPU requester, external loader/debug requester and
// the single-ported synchronous memory shared between them.
interface dm_arbiter_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt;
    logic       cpu_stall;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;

    logic       ext_req;
    logic       ext_we;
    logic [7:0] ext_addr;
    logic [7:0] ext_wdata;
    logic       ext_lock;
    logic       ext_gnt;
    logic       ext_rvalid;
    logic [7:0] ext_rdata;

    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    // Requesters and the memory model sit on the master side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter: CPU priority with bounded starvation of the
// external port, optional external bus lock, 1-cycle read return per port.
module dm_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    typedef enum logic {ARB, EXT_LOCKED} state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_starve_cnt;
    logic [2:0] w_starve_nxt;
    logic       w_cpu_gnt;
    logic       w_ext_gnt;

    logic       r_cpu_rvalid_p1;
    logic       r_ext_rvalid_p1;
    logic [7:0] r_cpu_rdata_p1;
    logic [7:0] r_ext_rdata_p1;

    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_ext_gnt    = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        if (!reset) begin
            if (r_state == EXT_LOCKED && bus.ext_lock) begin
                w_ext_gnt = bus.ext_req;
            end else begin
                // The lock-release cycle falls through here and is arbitrated normally.
                if (bus.cpu_req && bus.ext_req) begin
                    w_ext_gnt = (r_starve_cnt == STARVE_LIM);
                    w_cpu_gnt = ~w_ext_gnt;
                end else begin
                    w_cpu_gnt = bus.cpu_req;
                    w_ext_gnt = bus.ext_req;
                end
                w_state_nxt = (w_ext_gnt && bus.ext_lock) ? EXT_LOCKED : ARB;
            end

            if (w_ext_gnt) begin
                w_starve_nxt = 3'd0;
            end else if (w_cpu_gnt && bus.ext_req && r_starve_cnt < STARVE_LIM) begin
                w_starve_nxt = r_starve_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_starve_cnt <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Stage p0 -> p1: granted reads return on the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid_p1 <= 1'b0;
            r_ext_rvalid_p1 <= 1'b0;
            r_cpu_rdata_p1  <= 8'h00;
            r_ext_rdata_p1  <= 8'h00;
        end else begin
            r_cpu_rvalid_p1 <= w_cpu_gnt & ~bus.cpu_we;
            r_ext_rvalid_p1 <= w_ext_gnt & ~bus.ext_we;
            if (r_cpu_rvalid_p1) r_cpu_rdata_p1 <= bus.mem_rdata;
            if (r_ext_rvalid_p1) r_ext_rdata_p1 <= bus.mem_rdata;
        end
    end

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.ext_gnt   = w_ext_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_gnt & ~reset;

    assign bus.mem_we    = (w_cpu_gnt & bus.cpu_we) | (w_ext_gnt & bus.ext_we);
    assign bus.mem_addr  = w_cpu_gnt ? bus.cpu_addr  : (w_ext_gnt ? bus.ext_addr  : 8'h00);
    assign bus.mem_wdata = w_cpu_gnt ? bus.cpu_wdata : (w_ext_gnt ? bus.ext_wdata : 8'h00);

    // Read data passes straight through on the rvalid cycle, then is held.
    assign bus.cpu_rvalid = r_cpu_rvalid_p1 & ~reset;
    assign bus.ext_rvalid = r_ext_rvalid_p1 & ~reset;
    assign bus.cpu_rdata  = reset ? 8'h00 : (r_cpu_rvalid_p1 ? bus.mem_rdata : r_cpu_rdata_p1);
    assign bus.ext_rdata  = reset ? 8'h00 : (r_ext_rvalid_p1 ? bus.mem_rdata : r_ext_rdata_p1);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_dm_arbiter;

    localparam int SM = 3;

    logic clk;
    logic reset;
    dm_arbiter_if bus();

    dm_arbiter #(.STARVE_MAX(SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        return (a == 16) ? 8'h5A : 8'(a * 37 + 11);
    endfunction

    // Synchronous-read memory attached to the arbiter.
    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    bit         m_locked;
    int         m_starve;
    bit         m_cpu_pend, m_ext_pend;
    logic [7:0] m_cpu_pdata, m_ext_pdata, m_cpu_hold, m_ext_hold;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst,
                        input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                        input bit er, input bit ew, input logic [7:0] ea, input logic [7:0] ed,
                        input bit el);
        bit cg, eg;
        logic       x_we;
        logic [7:0] x_addr, x_wdata;
        reset         = rst;
        bus.cpu_req   = cr;  bus.cpu_we  = cw;  bus.cpu_addr  = ca;  bus.cpu_wdata = cd;
        bus.ext_req   = er;  bus.ext_we  = ew;  bus.ext_addr  = ea;  bus.ext_wdata = ed;
        bus.ext_lock  = el;
        #1;
        cg = 1'b0;
        eg = 1'b0;
        if (!rst) begin
            if (m_locked && el) eg = er;
            else if (cr && er) begin
                eg = (m_starve == SM);
                cg = !eg;
            end else begin
                cg = cr;
                eg = er;
            end
        end
        x_we    = (cg && cw) || (eg && ew);
        x_addr  = cg ? ca : (eg ? ea : 8'h00);
        x_wdata = cg ? cd : (eg ? ed : 8'h00);

        chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(cg));
        chk("ext_gnt",    32'(bus.ext_gnt),    32'(eg));
        chk("cpu_stall",  32'(bus.cpu_stall),  32'(!rst && cr && !cg));
        chk("mem_we",     32'(bus.mem_we),     32'(x_we));
        chk("mem_addr",   32'(bus.mem_addr),   32'(x_addr));
        chk("mem_wdata",  32'(bus.mem_wdata),  32'(x_wdata));
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!rst && m_cpu_pend));
        chk("ext_rvalid", 32'(bus.ext_rvalid), 32'(!rst && m_ext_pend));
        chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(rst ? 8'h00 : (m_cpu_pend ? m_cpu_pdata : m_cpu_hold)));
        chk("ext_rdata",  32'(bus.ext_rdata),  32'(rst ? 8'h00 : (m_ext_pend ? m_ext_pdata : m_ext_hold)));
        chk("starve_cnt", 32'(dut.r_starve_cnt), 32'(m_starve));
        chk("locked",     32'(dut.r_state),    32'(m_locked));

        if (rst) begin
            m_locked   = 1'b0;
            m_starve   = 0;
            m_cpu_pend = 1'b0;
            m_ext_pend = 1'b0;
            m_cpu_hold = 8'h00;
            m_ext_hold = 8'h00;
        end else begin
            if (m_cpu_pend) m_cpu_hold = m_cpu_pdata;
            if (m_ext_pend) m_ext_hold = m_ext_pdata;
            m_cpu_pend  = cg && !cw;
            m_ext_pend  = eg && !ew;
            m_cpu_pdata = ref_mem[ca];
            m_ext_pdata = ref_mem[ea];
            if (cg && cw) ref_mem[ca] = cd;
            if (eg && ew) ref_mem[ea] = ed;
            m_locked = el && (m_locked || eg);
            if (eg) m_starve = 0;
            else if (cg && er && m_starve < SM) m_starve++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_locked = 0; m_starve = 0; m_cpu_pend = 0; m_ext_pend = 0;
        m_cpu_pdata = 0; m_ext_pdata = 0; m_cpu_hold = 0; m_ext_hold = 0;
        reset = 1'b1;
        @(negedge clk);

        // Reset with active requests: everything must stay quiet
        for (int i = 0; i < 3; i++) step(1, 1,0,8'h10,8'h11, 1,1,8'h22,8'h33, 1);

        // CPU-only read of 0x10 (holds 0x5A)
        step(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0);
        idle(2);
        chk("req039_hold", 32'(bus.cpu_rdata), 32'h5A);

        // Continuous contention: C,C,C,E,C,C,C,E,C,C,C leaves starve at the limit
        for (int i = 0; i < 11; i++)
            step(0, 1,0,8'(i),8'h00, 1,0,8'(8'h40 + i),8'h00, 0);

        // Locked external writes to 0x00..0x03 while CPU waits, then lock drops
        for (int i = 0; i < 4; i++)
            step(0, 1,0,8'h05,8'h00, 1,1,8'(i),8'(8'hE0 + i), 1);
        step(0, 1,0,8'h02,8'h00, 0,0,8'h00,8'h00, 0);
        idle(1);
        chk("req041_rd", 32'(bus.cpu_rdata), 32'hE2);

        // External write then immediate CPU read of the same address
        step(0, 0,0,8'h00,8'h00, 1,1,8'h20,8'hC3, 0);
        step(0, 1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 0);
        idle(1);
        chk("req042_rd", 32'(bus.cpu_rdata), 32'hC3);

        // Locked ext read, then reset the following cycle, then CPU-only
        step(0, 0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 1);
        step(1, 0,0,8'h00,8'h00, 1,0,8'h31,8'h00, 1);
        step(0, 1,0,8'h11,8'h00, 0,0,8'h00,8'h00, 0);
        idle(4);

        // Random traffic on a narrow address window so read-after-write hits occur
        for (int i = 0; i < 2000; i++) begin
            bit rr, cr, cw, er, ew, el;
            rr = ($urandom_range(0, 63) == 0);
            cr = ($urandom_range(0, 3) != 0);
            cw = $urandom_range(0, 1);
            er = ($urandom_range(0, 2) != 0);
            ew = $urandom_range(0, 1);
            el = ($urandom_range(0, 3) == 0);
            step(rr, cr, cw, 8'($urandom_range(0, 15)), 8'($urandom),
                     er, ew, 8'($urandom_range(0, 15)), 8'($urandom), el);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
